// File: rtl/fpu_iter_normalizer.sv
// Iterative FPU normalizer: shifts left up to SHIFT_STEP bits per cycle, or right
// by one on carry, then holds the packed result until the consumer takes it.
module fpu_iter_normalizer #(
   parameter int MANT_W     = 23,
   parameter int EXP_W      = 8,
   parameter int SHIFT_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W+1:0] in_mantissa,
   input  logic [EXP_W-1:0]  in_exponent,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] out_mantissa,
   output logic [EXP_W-1:0]  out_exponent,
   output logic              overflow,
   output logic              underflow,
   output logic              zero,
   output logic              inexact
);

   localparam int LZ_W = $clog2(MANT_W + 2);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t            state, state_next;
   logic [MANT_W+1:0] m, m_next;
   logic [EXP_W-1:0]  e, e_next;
   logic              ov_next, un_next, zr_next, ix_next;
   logic [LZ_W-1:0]   step;
   logic              fin;

   // Leading zeros of the hidden-bit-and-below field; highest set bit wins.
   function automatic logic [LZ_W-1:0] lead_zeros(input logic [MANT_W:0] v);
      lead_zeros = LZ_W'(MANT_W + 1);
      for (int i = 0; i <= MANT_W; i++) begin
         if (v[i]) lead_zeros = LZ_W'(MANT_W - i);
      end
   endfunction

   // Per-cycle shift: never past the hidden bit, the step limit, or exponent zero.
   function automatic logic [LZ_W-1:0] shift_amt(input logic [LZ_W-1:0] lz,
                                                 input logic [EXP_W-1:0] ex);
      int s;
      s = int'(lz);
      if (SHIFT_STEP < s) s = SHIFT_STEP;
      if (int'(ex) < s) s = int'(ex);
      shift_amt = LZ_W'(s);
   endfunction

   assign step = shift_amt(lead_zeros(m[MANT_W:0]), e);

   always_comb begin
      state_next = state;
      m_next     = m;
      e_next     = e;
      ov_next    = overflow;
      un_next    = underflow;
      zr_next    = zero;
      ix_next    = inexact;
      fin        = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = NORM;
               m_next     = in_mantissa;
               e_next     = in_exponent;
               ov_next    = 1'b0;
               un_next    = 1'b0;
               zr_next    = 1'b0;
               ix_next    = 1'b0;
            end
         end
         NORM: begin
            if (m == '0) begin
               e_next  = '0;
               zr_next = 1'b1;
               fin     = 1'b1;
            end else if (m[MANT_W+1]) begin
               if (&e) begin
                  fin = 1'b1;
               end else begin
                  m_next  = m >> 1;
                  e_next  = e + 1'b1;
                  ix_next = m[0];
               end
            end else if (m[MANT_W] || (e == '0)) begin
               fin = 1'b1;
            end else begin
               m_next = m << step;
               e_next = e - EXP_W'(step);
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Status is settled from the final values as the result is published.
      if (fin) begin
         state_next = DONE;
         ov_next    = &e_next;
         un_next    = (e_next == '0) && (m_next != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         m         <= '0;
         e         <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         zero      <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         state     <= state_next;
         m         <= m_next;
         e         <= e_next;
         overflow  <= ov_next;
         underflow <= un_next;
         zero      <= zr_next;
         inexact   <= ix_next;
      end
   end

   assign in_ready     = (state == IDLE) && !rst;
   assign out_valid    = (state == DONE);
   assign out_mantissa = m[MANT_W-1:0];
   assign out_exponent = e;

endmodule

// File: tb/tb_fpu_iter_normalizer.sv
// Scoreboard bench for fpu_iter_normalizer: directed vectors, backpressure,
// mid-operation reset, and randomized operands against an arithmetic model.
module tb_fpu_iter_normalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] in_mantissa;
   logic [7:0]  in_exponent;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] out_mantissa;
   logic [7:0]  out_exponent;
   logic        overflow, underflow, zero, inexact;

   fpu_iter_normalizer #(.MANT_W(23), .EXP_W(8), .SHIFT_STEP(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mantissa(in_mantissa), .in_exponent(in_exponent),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mantissa(out_mantissa), .out_exponent(out_exponent),
      .overflow(overflow), .underflow(underflow), .zero(zero), .inexact(inexact)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [22:0] mant;
      logic [7:0]  ex;
      logic [3:0]  fl;   // {overflow, underflow, zero, inexact}
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   rand_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [22:0] mant, input logic [7:0] ex,
                               input logic [3:0] fl, input int lat);
      exp_t x;
      x.mant = mant; x.ex = ex; x.fl = fl; x.lat = lat; x.acc = 0;
      return x;
   endfunction

   // Whole-operation model: total shift distance first, then cycle count from it.
   function automatic exp_t model(input logic [24:0] mv, input logic [7:0] ev);
      int mi, ei, lz, t, k, lat, ix;
      mi = int'(mv); ei = int'(ev); ix = 0; lat = 1;
      if (mi == 0) begin
         return mk(23'h0, 8'h00, 4'b0010, 1);
      end else if ((mi >> 24) != 0) begin
         if (ei != 255) begin
            ix = mi & 1; mi = mi >> 1; ei = ei + 1; lat = 2;
         end
      end else if (((mi >> 23) & 1) == 0 && ei != 0) begin
         lz = 0; t = mi;
         while (((t >> 23) & 1) == 0) begin t = t << 1; lz++; end
         k = (lz < ei) ? lz : ei;
         mi = mi << k; ei = ei - k;
         lat = (k + 3) / 4 + 1;
      end
      return mk(23'(mi & 32'h7FFFFF), 8'(ei),
                {ei == 255, (ei == 0) && (mi != 0), 1'b0, ix != 0}, lat);
   endfunction

   // Monitor: latency on out_valid rise, stability under backpressure, values on handshake.
   logic        pv = 1'b0, pr = 1'b0;
   logic [34:0] prev_out;
   always @(negedge clk) begin
      if (out_valid && !pv) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_output: got out_valid=1 expected no result pending");
         end else begin
            chk("latency", cyc - q[0].acc, q[0].lat);
         end
      end
      if (out_valid && pv && !pr)
         chk("hold_stable", {out_mantissa, out_exponent, overflow, underflow, zero, inexact},
             prev_out);
      if (out_valid && out_ready && q.size() > 0) begin
         chk("out_mantissa", out_mantissa, q[0].mant);
         chk("out_exponent", out_exponent, q[0].ex);
         chk("flags", {overflow, underflow, zero, inexact}, q[0].fl);
         void'(q.pop_front());
      end
      pv = out_valid;
      pr = out_ready;
      prev_out = {out_mantissa, out_exponent, overflow, underflow, zero, inexact};
   end

   task automatic accept_op(input logic [24:0] mv, input logic [7:0] ev, input exp_t x);
      int n;
      in_valid = 1'b1; in_mantissa = mv; in_exponent = ev;
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("accept_ready", in_ready, 1);
      @(posedge clk); #1;
      x.acc = cyc;
      q.push_back(x);
      in_valid = 1'b0;
      in_mantissa = 25'($urandom);
      in_exponent = 8'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(posedge clk); #1; n++;
         if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      end
      if (q.size() > 0) begin
         tests++; fails++;
         $display("FAIL result_timeout: got no handshake expected one within 200 cycles");
         q.delete();
      end
      out_ready = 1'b1;
   endtask

   logic [24:0] dm[8] = '{25'h1800000, 25'h1800001, 25'h0002000, 25'h0800000,
                          25'h0000001, 25'h0000000, 25'h1000000, 25'h1000000};
   logic [7:0]  de[8] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h03, 8'h55, 8'hFE, 8'hFF};
   exp_t        dx[8];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no end expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [24:0] mv;
      logic [7:0]  ev;
      int          n, lz, cls;
      dx[0] = mk(23'h400000, 8'h81, 4'b0000, 2);
      dx[1] = mk(23'h400000, 8'h81, 4'b0001, 2);
      dx[2] = mk(23'h000000, 8'h76, 4'b0000, 4);
      dx[3] = mk(23'h000000, 8'h80, 4'b0000, 1);
      dx[4] = mk(23'h000008, 8'h00, 4'b0100, 2);
      dx[5] = mk(23'h000000, 8'h00, 4'b0010, 1);
      dx[6] = mk(23'h000000, 8'hFF, 4'b1000, 2);
      dx[7] = mk(23'h000000, 8'hFF, 4'b1000, 1);

      rst = 1'b1; in_valid = 1'b0; in_mantissa = '0; in_exponent = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mantissa", out_mantissa, 0);
      chk("rst_exponent", out_exponent, 0);
      chk("rst_flags", {overflow, underflow, zero, inexact}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_rst", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         accept_op(dm[i], de[i], dx[i]);
         wait_done();
      end

      // Backpressure while the input side is hammered with junk.
      out_ready = 1'b0;
      accept_op(dm[1], de[1], dx[1]);
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_reached_done", out_valid, 1);
      repeat (5) begin
         in_valid = 1'($urandom_range(0, 1));
         in_mantissa = 25'($urandom);
         in_exponent = 8'($urandom);
         @(posedge clk); #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_in_ready_after_hs", in_ready, 1);
      chk("bp_single_handshake", q.size(), 0);
      accept_op(dm[0], de[0], dx[0]);
      wait_done();

      // Reset during the second NORM cycle of the left-shift case.
      accept_op(dm[2], de[2], dx[2]);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_mantissa", out_mantissa, 0);
      chk("mid_rst_exponent", out_exponent, 0);
      chk("mid_rst_flags", {overflow, underflow, zero, inexact}, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      accept_op(dm[2], de[2], dx[2]);
      wait_done();

      rand_mode = 1'b1;
      for (int i = 0; i < 60; i++) begin
         cls = $urandom_range(0, 4);
         ev = 8'($urandom);
         case (cls)
            0: mv = 25'h0;
            1: mv = 25'h1000000 | 25'($urandom_range(0, 32'hFFFFFF));
            2: mv = 25'h0800000 | 25'($urandom_range(0, 32'h7FFFFF));
            3: begin
               lz = $urandom_range(1, 23);
               mv = 25'(32'h1 << (23 - lz)) | 25'($urandom & ((32'h1 << (23 - lz)) - 1));
               if ($urandom_range(0, 1) == 1) ev = 8'($urandom_range(0, 8));
            end
            default: mv = 25'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) ev = 8'hFF;
         accept_op(mv, ev, model(mv, ev));
         wait_done();
      end
      rand_mode = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
